// File: rtl/rv_defs_pkg.sv
// rv_defs_pkg: shared RV32I load/store encodings, LSU error codes, LSU FSM states and op legality check
//   F3_*          funct3 width/sign encodings for loads and stores
//   LSU_ERR_*     completion codes reported with done
//   lsu_state_e   LSU control FSM states
//   lsu_check()   classifies an op as ok / misaligned / illegal
package rv_defs_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LSU_ERR_OK       = 2'd0;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {LSU_IDLE, LSU_BUS, LSU_RESP} lsu_state_e;

    // Illegal takes priority over misalignment; a no-op (neither load nor store) is always ok.
    function automatic logic [1:0] lsu_check(input logic ld, input logic st, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic illegal;
        logic mis;
        illegal = (ld && st) || (st && (f3[2] || f3[1:0] == 2'b11)) ||
                  (ld && (f3[1:0] == 2'b11 || (f3[2] && f3[1])));
        mis = (ld || st) && ((f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00));
        return illegal ? LSU_ERR_ILLEGAL : mis ? LSU_ERR_MISALIGN : LSU_ERR_OK;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational store lane replication/strobes and load lane extract with extension
//   st_funct3, st_addr_lo, store_data -> wdata, wstrb
//   ld_funct3, ld_addr_lo, rdata      -> load_val
module lsu_lane_align
    import rv_defs_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_val
);
    logic [31:0] shifted;
    logic [15:0] half;
    logic        sext;

    assign wdata = st_funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                   st_funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    assign wstrb = st_funct3[1:0] == 2'b00 ? 4'b0001 << st_addr_lo :
                   st_funct3[1:0] == 2'b01 ? 4'b0011 << st_addr_lo : 4'b1111;

    assign shifted  = rdata >> {ld_addr_lo, 3'b000};
    assign half     = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // funct3[2] marks the unsigned variants
    assign sext     = ~ld_funct3[2];
    assign load_val = ld_funct3[1:0] == 2'b00 ? {{24{sext & shifted[7]}}, shifted[7:0]} :
                      ld_funct3[1:0] == 2'b01 ? {{16{sext & half[15]}}, half} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage, one load/store per start over a req/ready bus
//   start/is_load/is_store/funct3/addr/store_data : op request from control
//   mem_req/we/addr/wstrb/wdata, mem_rdata/ready  : data bus
//   done/err                                      : completion pulse and status
//   load_result                                   : extended data of the last successful load
module load_store_unit
    import rv_defs_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] load_result
);
    lsu_state_e  state, state_n;
    logic [1:0]  chk;
    logic        go_bus, tmo, op_load;
    logic [31:0] cnt, st_wdata, ld_val;
    logic [3:0]  st_strb;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;

    assign chk    = lsu_check(is_load, is_store, funct3, addr[1:0]);
    assign go_bus = (is_load || is_store) && chk == LSU_ERR_OK;
    // ready in the limit cycle wins over the timeout
    assign tmo    = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1) && !mem_ready;

    lsu_lane_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (addr[1:0]),
        .store_data (store_data),
        .ld_funct3  (ld_f3),
        .ld_addr_lo (ld_lo),
        .rdata      (mem_rdata),
        .wdata      (st_wdata),
        .wstrb      (st_strb),
        .load_val   (ld_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LSU_IDLE: state_n = start ? (go_bus ? LSU_BUS : LSU_RESP) : LSU_IDLE;
            LSU_BUS:  state_n = (mem_ready || tmo) ? LSU_RESP : LSU_BUS;
            default:  state_n = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            done        <= 1'b0;
            err         <= LSU_ERR_OK;
            load_result <= '0;
            cnt         <= '0;
            ld_f3       <= '0;
            ld_lo       <= '0;
            op_load     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= LSU_ERR_OK;
            case (state)
                LSU_IDLE: begin
                    if (start && go_bus) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wstrb <= is_store ? st_strb : 4'b0000;
                        mem_wdata <= is_store ? st_wdata : 32'd0;
                        cnt       <= '0;
                        ld_f3     <= funct3;
                        ld_lo     <= addr[1:0];
                        op_load   <= is_load;
                    end else if (start) begin
                        done <= 1'b1;
                        err  <= chk;
                    end
                end
                LSU_BUS: begin
                    if (mem_ready || tmo) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        done      <= 1'b1;
                        err       <= mem_ready ? LSU_ERR_OK : LSU_ERR_TIMEOUT;
                        if (mem_ready && op_load) load_result <= ld_val;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized self-checking bench against a behavioural LSU model
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0, is_load = 0, is_store = 0, mem_ready = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
    logic        mem_req, mem_we, done;
    logic [31:0] mem_addr, mem_wdata, load_result;
    logic [3:0]  mem_wstrb;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;
    logic [31:0] lr = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .done(done), .err(err),
        .load_result(load_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op; dly = number of req cycles with ready low before ready rises (>= TO never rises).
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int dly);
        int          sz, off;
        logic [1:0]  e;
        logic [3:0]  xs;
        logic [31:0] xw, mask, v;
        bit          bus, timed;
        sz  = 1 << f3[1:0];
        off = int'(a % 4);
        if (ld && st) e = 3;
        else if (st && f3 > 3'd2) e = 3;
        else if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 3;
        else if ((ld || st) && (a % sz) != 0) e = 1;
        else e = 0;
        bus = (ld || st) && e == 0;
        xs = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        for (int j = 0; j < 4; j++) xw[j*8 +: 8] = d[(j % sz)*8 +: 8];
        start = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
        tick();
        start = 0; is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        if (!bus) begin
            check("nobus_req", 32'(mem_req), 0);
            check("nobus_done", 32'(done), 1);
            check("nobus_err", 32'(err), 32'(e));
        end else begin
            for (int k = 0; k < TO; k++) begin
                check("bus_req", 32'(mem_req), 1);
                check("bus_we", 32'(mem_we), 32'(st));
                check("bus_addr", mem_addr, a & ~32'd3);
                check("bus_strb", 32'(mem_wstrb), 32'(xs));
                if (st) check("bus_wdata", mem_wdata, xw);
                check("bus_done", 32'(done), 0);
                mem_ready = (k == dly);
                mem_rdata = rd;
                start = 1'($urandom);
                tick();
                mem_ready = 0; mem_rdata = $urandom; start = 0;
                if (k == dly) break;
            end
            timed = dly >= TO;
            check("end_done", 32'(done), 1);
            check("end_err", 32'(err), timed ? 2 : 0);
            check("end_req", 32'(mem_req), 0);
            if (ld && !timed) begin
                v = rd >> (8 * off);
                if (sz < 4) begin
                    mask = (32'd1 << (8 * sz)) - 1;
                    v = v & mask;
                    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
                end
                lr = v;
            end
        end
        check("load_result", load_result, lr);
        tick();
        check("after_done", 32'(done), 0);
        check("after_err", 32'(err), 0);
    endtask

    initial begin
        tick();
        check("rst_req", 32'(mem_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_lr", load_result, 0);
        check("rst_strb", 32'(mem_wstrb), 0);
        rst = 0;
        tick();
        run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
        run_op(1, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0);
        check("lb_val", load_result, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 0);
        check("lbu_val", load_result, 32'h00000080);
        run_op(1, 0, 3'b101, 32'h202, 0, 32'h80FF1234, 1);
        check("lhu_val", load_result, 32'h000080FF);
        run_op(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 3);
        run_op(1, 0, 3'b010, 32'h101, 0, 0, 0);
        check("mis_keep", load_result, 32'h000080FF);
        run_op(1, 0, 3'b010, 32'h40, 0, 32'h12345678, 99);
        run_op(1, 0, 3'b010, 32'h40, 0, 32'h12345678, 3);
        run_op(0, 0, 3'b000, 32'h0, 0, 0, 0);
        run_op(1, 1, 3'b010, 32'h0, 0, 0, 0);
        run_op(0, 1, 3'b100, 32'h0, 0, 0, 0);
        run_op(1, 0, 3'b110, 32'h0, 0, 0, 0);
        // reset during the bus phase
        start = 1; is_load = 0; is_store = 1; funct3 = 3'b010; addr = 32'h80; store_data = 32'h1;
        tick();
        start = 0;
        check("pre_rst_req", 32'(mem_req), 1);
        rst = 1;
        #1;
        check("mid_rst_req", 32'(mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_done", 32'(done), 0);
        end
        rst = 0;
        lr = 0;
        tick();
        run_op(1, 0, 3'b010, 32'h84, 0, 32'hCAFEF00D, 1);
        for (int i = 0; i < 200; i++) begin
            int          r;
            logic [2:0]  f;
            logic [31:0] a;
            r = int'($urandom % 10);
            f = 3'($urandom);
            a = $urandom;
            if ($urandom % 2 == 0) a = a & ~((32'd1 << f[1:0]) - 1);
            run_op(r < 5 || r == 9, (r >= 5 && r < 9) || r == 9, f, a, $urandom, $urandom,
                   int'($urandom % 6));
            if (($urandom % 4) == 0) tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
